// File: rtl/seg_scan_mux_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: glyph table,
// segment bit positions and a width helper for the internal counters.
package seg_pkg;

    localparam int SEG_W = 8;   // a..g plus decimal point
    localparam int NIB_W = 4;   // one hexadecimal digit

    // Bit positions inside a shape byte (active-high segments).
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

    // Hexadecimal glyphs 0..F, segments a..g in bits 0..6.
    localparam logic [SEG_G:SEG_A] SEG_HEX [16] = '{
        7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
        7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
    };

    // Register width for a counter that spans 0..n-1; never narrower than 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Bundle between the clock/counter datapath (master) and the display
// scanner (slave): digit values and display controls in, pin drives out.
interface seg_scan_mux_if
    import seg_pkg::*;
#(
    parameter int DIGITS = 4
);

    logic [NIB_W*DIGITS-1:0] digits_in;     // nibble DIGITS-1 is leftmost
    logic [DIGITS-1:0]       dp_in;         // decimal point per digit
    logic                    lz_blank;      // suppress leading zeros
    logic [DIGITS-1:0]       blink_mask;    // 1 = digit blinks
    logic [SEG_W-1:0]        shape;         // segments, active-high
    logic [DIGITS-1:0]       choose_light;  // digit select, active-low

    modport master (
        output digits_in, dp_in, lz_blank, blink_mask,
        input  shape, choose_light
    );

    modport slave (
        input  digits_in, dp_in, lz_blank, blink_mask,
        output shape, choose_light
    );

endinterface

// File: rtl/seg_scan_mux_decode.sv
// Combinational glyph decoder: one nibble plus its decimal point becomes a
// segment byte; a blanked slot shows nothing, decimal point included.
module seg_decode
    import seg_pkg::*;
(
    input  logic [NIB_W-1:0] i_value,
    input  logic             i_dp,
    input  logic             i_blank,
    output logic [SEG_W-1:0] o_shape
);

    // Look up the glyph and append the dp unless the slot is blanked.
    always_comb begin
        // NOTE: the default assignment first means every path drives o_shape, so no latch is inferred.
        o_shape = SEG_BLANK;
        if (!i_blank) begin
            o_shape[SEG_G:SEG_A] = SEG_HEX[i_value];
            o_shape[SEG_DP]      = i_dp;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scanner: refresh prescaler, digit scan index,
// per-frame input latch, leading-zero suppression and per-digit blinking.
// shape and choose_light are registered together so every visible pair is
// consistent.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int DIGITS    = 4,        // digit positions, 1..16
    parameter int SCAN_DIV  = 50000,    // clk cycles each digit stays lit
    parameter int BLINK_DIV = 64        // frames per blink half-period
)(
    input  logic          clk,
    input  logic          rst,          // synchronous, active-high
    seg_scan_mux_if.slave bus
);

    localparam int IDX_W  = cnt_width(DIGITS);
    localparam int PCNT_W = cnt_width(SCAN_DIV);
    localparam int FCNT_W = cnt_width(BLINK_DIV);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SCAN_DIV - 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_DIV - 1);

    // Scan and blink state.
    logic [PCNT_W-1:0]       r_pcnt;
    logic [IDX_W-1:0]        r_idx;         // 0 = leftmost digit
    logic [FCNT_W-1:0]       r_fcnt;
    logic                    r_phase;       // 1 = masked digits dark
    logic                    r_started;     // a frame has been shown since reset

    // Frame latch: inputs as captured at the start of the current frame.
    logic [NIB_W*DIGITS-1:0] r_digits;
    logic [DIGITS-1:0]       r_dp;
    logic                    r_lz;
    logic [DIGITS-1:0]       r_blink;

    // Pin registers.
    logic [SEG_W-1:0]        r_shape;
    logic [DIGITS-1:0]       r_choose_light;

    // Next-state and slot decode.
    logic                    w_tick;
    logic [PCNT_W-1:0]       w_next_pcnt;
    logic [IDX_W-1:0]        w_next_idx;
    logic                    w_capture;
    logic                    w_frame_end;
    logic [FCNT_W-1:0]       w_next_fcnt;
    logic                    w_next_phase;
    logic [NIB_W*DIGITS-1:0] w_src_digits;
    logic [DIGITS-1:0]       w_src_dp;
    logic                    w_src_lz;
    logic [DIGITS-1:0]       w_src_blink;
    logic                    w_zero_run;
    logic [DIGITS-1:0]       w_lz_mask;
    int                      w_sel;         // nibble number of the slot being lit
    logic [NIB_W-1:0]        w_value;
    logic                    w_dp;
    logic                    w_blank;
    logic [SEG_W-1:0]        w_shape;
    logic [DIGITS-1:0]       w_choose;

    // Prescaler tick, scan advance, frame boundary and blink phase sequencing.
    always_comb begin
        w_tick      = (r_pcnt == PCNT_LAST);
        w_next_pcnt = w_tick ? '0 : r_pcnt + 1'b1;

        w_next_idx = r_idx;
        if (w_tick) begin
            w_next_idx = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end

        // The tick that lands on the leftmost digit opens a new frame. The
        // very first one after reset opens frame 0 without closing a frame,
        // so it does not advance the blink counter.
        w_capture   = w_tick && (w_next_idx == '0);
        w_frame_end = w_capture && r_started;

        w_next_fcnt  = r_fcnt;
        w_next_phase = r_phase;
        if (w_frame_end) begin
            if (r_fcnt == FCNT_LAST) begin
                w_next_fcnt  = '0;
                w_next_phase = ~r_phase;
            end else begin
                w_next_fcnt = r_fcnt + 1'b1;
            end
        end
    end

    // Frame source (live inputs on the capturing edge) and leading-zero mask,
    // walked left to right; the rightmost nibble is never suppressed.
    always_comb begin
        w_src_digits = w_capture ? bus.digits_in  : r_digits;
        w_src_dp     = w_capture ? bus.dp_in      : r_dp;
        w_src_lz     = w_capture ? bus.lz_blank   : r_lz;
        w_src_blink  = w_capture ? bus.blink_mask : r_blink;

        w_zero_run = 1'b1;
        w_lz_mask  = '0;
        for (int n = DIGITS - 1; n >= 1; n--) begin
            w_zero_run   = w_zero_run && (NIB_W'(w_src_digits >> (NIB_W * n)) == '0);
            w_lz_mask[n] = w_src_lz && w_zero_run;
        end
    end

    // Select the nibble, dp and blank state for the slot lit on the next tick.
    always_comb begin
        w_sel    = DIGITS - 1 - int'(w_next_idx);
        w_value  = NIB_W'(w_src_digits >> (NIB_W * w_sel));
        w_dp     = 1'(w_src_dp >> w_sel);
        w_blank  = 1'(w_lz_mask >> w_sel) | (1'(w_src_blink >> w_sel) & w_next_phase);
        w_choose = ~(DIGITS'(1) << w_sel);
    end

    seg_decode u_decode (
        .i_value (w_value),
        .i_dp    (w_dp),
        .i_blank (w_blank),
        .o_shape (w_shape)
    );

    // Counters, frame latch and pin registers; pins move only on a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt         <= '0;
            r_idx          <= IDX_LAST;
            r_fcnt         <= '0;
            r_phase        <= 1'b0;
            r_started      <= 1'b0;
            // NOTE: the frame latch is cleared as well, so reset leaves no stale digits behind.
            r_digits       <= '0;
            r_dp           <= '0;
            r_lz           <= 1'b0;
            r_blink        <= '0;
            r_shape        <= SEG_BLANK;
            r_choose_light <= '1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_pcnt <= w_next_pcnt;
            if (w_tick) begin
                r_idx          <= w_next_idx;
                r_shape        <= w_shape;
                r_choose_light <= w_choose;
            end
            if (w_capture) begin
                r_digits  <= bus.digits_in;
                r_dp      <= bus.dp_in;
                r_lz      <= bus.lz_blank;
                r_blink   <= bus.blink_mask;
                r_started <= 1'b1;
            end
            r_fcnt  <= w_next_fcnt;
            r_phase <= w_next_phase;
        end
    end

    assign bus.shape        = r_shape;
    assign bus.choose_light = r_choose_light;

endmodule
